// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port, fixed-latency memory between the cpu
//            fetch port and data port. Data has priority; fetch has a
//            starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              proto_err
);

    localparam logic [3:0] c_STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [2:0] c_LAT_LOAD   = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_streak;
    logic [2:0]          r_lat_cnt;
    logic                r_sel_d;
    logic                r_is_wr;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_proto_err;

    logic                w_d_req;
    logic                w_fetch_win;
    logic                w_grant;
    logic                w_capture;
    logic                w_if_ready;
    logic                w_d_ready;

    assign w_d_req     = d_rd | d_wr;
    // Fetch wins when it is alone, or when data has used up its streak.
    assign w_fetch_win = if_req & (~w_d_req | (r_streak == c_STREAK_MAX));

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_if_ready  = 1'b0;
        w_d_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (if_req | w_d_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = r_is_wr ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_if_ready  = ~r_sel_d;
                w_d_ready   = r_sel_d;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_streak    <= 4'd0;
            r_lat_cnt   <= 3'd0;
            r_sel_d     <= 1'b0;
            r_is_wr     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_en <= w_grant;
            r_mem_we <= w_grant & ~w_fetch_win & d_wr;

            if (w_grant) begin
                r_sel_d    <= ~w_fetch_win;
                r_is_wr    <= ~w_fetch_win & d_wr;
                r_mem_addr <= w_fetch_win ? if_addr : d_addr;
                if (!w_fetch_win) begin
                    r_mem_wdata <= d_wdata;
                end
                // Only data grants made while fetch waits extend the streak.
                if (w_fetch_win || !if_req) begin
                    r_streak <= 4'd0;
                end else if (r_streak < c_STREAK_MAX) begin
                    r_streak <= r_streak + 4'd1;
                end
            end

            if ((r_state == S_IDLE) && d_rd && d_wr) begin
                r_proto_err <= 1'b1;
            end

            if (r_state == S_ISSUE) begin
                r_lat_cnt <= c_LAT_LOAD;
            end else if ((r_state == S_WAIT) && (r_lat_cnt != 3'd0)) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end

            if (w_capture) begin
                if (r_sel_d) begin
                    r_d_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_ready  = w_if_ready;
    assign d_ready   = w_d_ready;
    // Drops in the ready cycle so the pipeline advances on that edge.
    assign stall     = (if_req & ~w_if_ready) | (w_d_req & ~w_d_ready);
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a behavioural
//            memory and a transaction-level arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 3;
    localparam int MAX_STREAK = 4;
    localparam int RD_LAT     = MEM_LAT + 2;
    localparam int WR_LAT     = 2;
    localparam int N_RND      = 1500;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        proto_err;

    mem_port_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .MEM_LAT   (MEM_LAT),
        .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .stall    (stall),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        if_req = 1'b0;
        d_rd   = 1'b0;
        d_wr   = 1'b0;
        go();
        go();
        reset  = 1'b0;
    endtask

    function automatic logic [15:0] mem_init(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA5C3 : (a ^ 16'hC0DE);
    endfunction

    // Behavioural memory: read data appears MEM_LAT cycles after the issue
    // cycle and is random noise at all other times.
    logic [15:0] mem_arr [int];
    int unsigned due_q[$];
    logic [15:0] dat_q[$];

    initial begin
        mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                mem_rdata = dat_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                mem_rdata = 16'($urandom);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (mem_en === 1'b1 && mem_we === 1'b0) begin
            due_q.push_back(cyc + MEM_LAT);
            dat_q.push_back(mem_arr.exists(int'(mem_addr)) ? mem_arr[int'(mem_addr)]
                                                           : mem_init(mem_addr));
        end else if (mem_en === 1'b1 && mem_we === 1'b1) begin
            mem_arr[int'(mem_addr)] = mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference memory for the randomized phase, written from stimulus only.
    logic [15:0] ref_mem [int];
    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_init(a);
    endfunction

    typedef struct {
        logic        f;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata;
        logic        proto;
    } vec_t;

    vec_t vec [8];

    // randomized-phase state
    logic        f_on, d_on, d_r, d_w, g_f, g_wr, g_valid;
    logic        exp_perr, perr_now, exp_ifr, exp_dr;
    logic [15:0] f_a, d_a, d_wd, g_addr, g_wd, g_rdata;
    int          s, free_at, g_issue, g_ready, r;
    logic        got[$];
    logic        exp_order [10];

    initial begin
        vec[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, RD_LAT, 16'hA5C3, 1'b0};
        vec[1] = '{1'b0, 1'b0, 1'b1, 16'h0200, 16'h1234, WR_LAT, 16'h0000, 1'b0};
        vec[2] = '{1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, RD_LAT, 16'h1234, 1'b0};
        vec[3] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, RD_LAT, 16'hA5C3, 1'b0};
        vec[4] = '{1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, RD_LAT, 16'h1234, 1'b0};
        vec[5] = '{1'b0, 1'b1, 1'b1, 16'h0030, 16'hBEEF, WR_LAT, 16'h0000, 1'b1};
        vec[6] = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, RD_LAT, 16'hBEEF, 1'b1};
        vec[7] = '{1'b1, 1'b0, 1'b0, 16'h0008, 16'h0000, RD_LAT, 16'hC0D6, 1'b1};
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        go();
        reset = 1'b0;

        // ---------------- single-access vector table ----------------
        for (int i = 0; i < 8; i++) begin
            if_req  = vec[i].f;
            if_addr = vec[i].addr;
            d_rd    = vec[i].rd;
            d_wr    = vec[i].wr;
            d_addr  = vec[i].addr;
            d_wdata = vec[i].wdata;
            for (int k = 0; k <= vec[i].lat; k++) begin
                @(negedge clk);
                chk("tbl_mem_en", 32'(mem_en), 32'(k == 1));
                if (k == 1) begin
                    chk("tbl_mem_addr", 32'(mem_addr), 32'(vec[i].addr));
                    chk("tbl_mem_we", 32'(mem_we), 32'(vec[i].wr));
                    if (vec[i].wr) chk("tbl_mem_wdata", 32'(mem_wdata), 32'(vec[i].wdata));
                end else begin
                    chk("tbl_mem_we_idle", 32'(mem_we), 32'd0);
                end
                chk("tbl_if_ready", 32'(if_ready), 32'((k == vec[i].lat) && vec[i].f));
                chk("tbl_d_ready", 32'(d_ready), 32'((k == vec[i].lat) && !vec[i].f));
                chk("tbl_stall", 32'(stall), 32'(k != vec[i].lat));
                if (k == vec[i].lat && !vec[i].wr) begin
                    if (vec[i].f) chk("tbl_if_rdata", 32'(if_rdata), 32'(vec[i].rdata));
                    else          chk("tbl_d_rdata", 32'(d_rdata), 32'(vec[i].rdata));
                end
                go();
            end
            if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
            @(negedge clk);
            chk("tbl_stall_after", 32'(stall), 32'd0);
            chk("tbl_proto_err", 32'(proto_err), 32'(vec[i].proto));
            go();
        end

        // ------------- simultaneous fetch + data read ---------------
        if_req = 1'b1; if_addr = 16'h0004;
        d_rd   = 1'b1; d_addr  = 16'h0008;
        for (int k = 0; k < 12; k++) begin
            if (k == 6) d_rd = 1'b0;
            @(negedge clk);
            chk("sim_mem_en", 32'(mem_en), 32'((k == 1) || (k == 7)));
            if (k == 1) chk("sim_addr_d", 32'(mem_addr), 32'h0008);
            if (k == 7) chk("sim_addr_f", 32'(mem_addr), 32'h0004);
            chk("sim_d_ready", 32'(d_ready), 32'(k == 5));
            chk("sim_if_ready", 32'(if_ready), 32'(k == 11));
            chk("sim_stall", 32'(stall), 32'(k != 11));
            if (k == 5)  chk("sim_d_rdata", 32'(d_rdata), 32'hC0D6);
            if (k == 11) chk("sim_if_rdata", 32'(if_rdata), 32'hC0DA);
            go();
        end
        if_req = 1'b0;
        @(negedge clk);
        chk("proto_sticky", 32'(proto_err), 32'd1);
        go();

        // ---------------- starvation guard ----------------
        do_reset();
        @(negedge clk);
        chk("proto_cleared", 32'(proto_err), 32'd0);
        go();
        if_req = 1'b1; if_addr = 16'h0040;
        d_rd   = 1'b1; d_addr  = 16'h0060;
        for (int k = 0; k < 120 && got.size() < 10; k++) begin
            @(negedge clk);
            if (mem_en === 1'b1) got.push_back(mem_addr == 16'h0040);
            go();
        end
        if_req = 1'b0; d_rd = 1'b0;
        chk("starve_grants", 32'(got.size()), 32'd10);
        for (int i = 0; i < got.size() && i < 10; i++)
            chk("starve_order", 32'(got[i]), 32'(exp_order[i]));
        for (int k = 0; k < 10; k++) go();
        @(negedge clk);
        chk("starve_if_rdata", 32'(if_rdata), 32'hC09E);
        chk("starve_d_rdata", 32'(d_rdata), 32'hC0BE);
        go();

        // ---------------- reset mid-access ----------------
        if_req = 1'b1; if_addr = 16'h0010;
        go();
        @(negedge clk);
        chk("mid_issue", 32'(mem_en), 32'd1);
        go();
        reset = 1'b1; if_req = 1'b0;
        go();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_mem_en", 32'(mem_en), 32'd0);
        chk("mid_if_rdata", 32'(if_rdata), 32'd0);
        chk("mid_d_rdata", 32'(d_rdata), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mid_no_ready", 32'({if_ready, d_ready}), 32'd0);
            go();
        end
        d_rd = 1'b1; d_addr = 16'h0008;
        for (int k = 0; k <= RD_LAT; k++) begin
            @(negedge clk);
            chk("mid_new_ready", 32'(d_ready), 32'(k == RD_LAT));
            if (k == RD_LAT) chk("mid_new_rdata", 32'(d_rdata), 32'hC0D6);
            go();
        end
        d_rd = 1'b0;
        go();

        // ---------------- randomized vs. transaction model ----------------
        do_reset();
        f_on = 0; d_on = 0; d_r = 0; d_w = 0; s = 0; exp_perr = 0; g_valid = 0;
        g_f = 0; g_wr = 0; free_at = 0; g_issue = -1; g_ready = -1;
        f_a = 16'h0100; d_a = 16'h0100; d_wd = 16'h0;
        g_addr = 16'h0; g_wd = 16'h0; g_rdata = 16'h0;
        for (int c = 0; c < N_RND; c++) begin
            if (!f_on && ($urandom % 4 != 0)) begin
                f_on = 1'b1;
                f_a  = 16'h0100 + 16'($urandom_range(0, 31) * 2);
            end
            if (!d_on && ($urandom % 3 != 0)) begin
                d_on = 1'b1;
                r    = int'($urandom_range(0, 15));
                d_r  = (r < 8) || (r == 15);
                d_w  = (r >= 8);
                d_a  = 16'h0100 + 16'($urandom_range(0, 31) * 2);
                d_wd = 16'($urandom);
            end
            if_req = f_on; if_addr = f_a;
            d_rd = d_on & d_r; d_wr = d_on & d_w; d_addr = d_a; d_wdata = d_wd;
            perr_now = exp_perr;
            if (c == free_at) begin
                if (f_on || d_on) begin
                    g_f = f_on && (!d_on || s == MAX_STREAK);
                    if (g_f)       s = 0;
                    else if (f_on) s = (s < MAX_STREAK) ? s + 1 : MAX_STREAK;
                    else           s = 0;
                    g_wr    = !g_f && d_w;
                    g_addr  = g_f ? f_a : d_a;
                    g_wd    = d_wd;
                    g_issue = c + 1;
                    g_ready = g_wr ? c + WR_LAT : c + RD_LAT;
                    g_rdata = g_wr ? 16'h0 : ref_read(g_addr);
                    if (g_wr) ref_mem[int'(g_addr)] = g_wd;
                    g_valid = 1'b1;
                    free_at = g_ready + 1;
                    if (d_on && d_r && d_w) exp_perr = 1'b1;
                end else begin
                    free_at = c + 1;
                end
            end
            @(negedge clk);
            exp_ifr = g_valid && (c == g_ready) && g_f;
            exp_dr  = g_valid && (c == g_ready) && !g_f;
            chk("rnd_if_ready", 32'(if_ready), 32'(exp_ifr));
            chk("rnd_d_ready", 32'(d_ready), 32'(exp_dr));
            chk("rnd_mem_en", 32'(mem_en), 32'(g_valid && c == g_issue));
            if (g_valid && c == g_issue) begin
                chk("rnd_mem_we", 32'(mem_we), 32'(g_wr));
                chk("rnd_mem_addr", 32'(mem_addr), 32'(g_addr));
                if (g_wr) chk("rnd_mem_wdata", 32'(mem_wdata), 32'(g_wd));
            end else begin
                chk("rnd_mem_we_idle", 32'(mem_we), 32'd0);
            end
            chk("rnd_stall", 32'(stall), 32'((f_on && !exp_ifr) || (d_on && !exp_dr)));
            if (exp_ifr) chk("rnd_if_rdata", 32'(if_rdata), 32'(g_rdata));
            if (exp_dr && !g_wr) chk("rnd_d_rdata", 32'(d_rdata), 32'(g_rdata));
            chk("rnd_proto_err", 32'(proto_err), 32'(perr_now));
            if (exp_ifr) f_on = 1'b0;
            if (exp_dr)  d_on = 1'b0;
            go();
        end
        if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        go();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
